parking_lane_arbiter: RTL and testbench
=======================================

// Module: parking_lane_arbiter
// PURPOSE
//  Shares the single parking-gate controller between an entry lane and an exit lane.
//  Grants the gate to one lane at a time and tracks lot occupancy against CAPACITY.
//  Refuses entry grants while the lot is full, and recovers stalled grants by timeout.
//  Sits upstream of the gate controller; its grant drives that controller's arrival input.
// PARAMETERS
//  CAPACITY        8    max vehicles in lot (>=1)
//  CNT_W           4    occupancy width; must satisfy 2**CNT_W > CAPACITY
//  TIMEOUT_CYCLES  64   max cycles a grant may stay open without done/abort (>=2)
//  TMR_W           7    timeout counter width; must satisfy 2**TMR_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  entry_req    in   1      level: vehicle waiting at entry lane
//  exit_req     in   1      level: vehicle waiting at exit lane
//  pass_done    in   1      1-cycle pulse from gate ctrl: granted vehicle passed
//  pass_abort   in   1      1-cycle pulse from gate ctrl: pass failed (wrong pin/blocked)
//  grant_entry  out  1      gate owned by entry lane
//  grant_exit   out  1      gate owned by exit lane
//  occupancy    out  CNT_W  vehicles currently in lot
//  lot_full     out  1      occupancy == CAPACITY
//  timeout      out  1      1-cycle pulse: grant released by timer
//  count_err    out  1      1-cycle pulse: exit pass completed with occupancy already 0
// BEHAVIOUR
//  - All outputs registered; reset values: grants 0, occupancy 0, lot_full 0, timeout 0, count_err 0.
//  - FSM states: IDLE, GNT_ENTRY, GNT_EXIT, HOLDOFF.
//    IDLE: eligible = {entry_req & ~lot_full, exit_req}. None eligible -> stay.
//      One eligible -> go to its GNT state. Both eligible -> round-robin:
//      the lane not in last_served wins. last_served reset value = EXIT, so entry wins first.
//    GNT_x: the grant for lane x is asserted, one-hot, from the cycle after the IDLE decision.
//      A 1-cycle request-to-grant latency is required.
//      pass_done -> HOLDOFF; next cycle occupancy +1 (entry) or -1 (exit).
//      pass_abort -> HOLDOFF; occupancy unchanged.
//      pass_done and pass_abort in the same cycle -> done wins.
//      Timer reaches TIMEOUT_CYCLES with neither pulse -> HOLDOFF, timeout pulses once, occupancy unchanged.
//      last_served <= x on any exit from GNT_x.
//      A request deasserting during GNT_x does not drop the grant; only done/abort/timeout do.
//    HOLDOFF: exactly 1 cycle with both grants 0 (gate closes), then IDLE.
//      Minimum back-to-back grant spacing is therefore 2 idle cycles.
//  - Timer: cleared on entering GNT_x, increments each cycle in GNT_x.
//    Timeout fires on the cycle the count equals TIMEOUT_CYCLES-1.
//  - Occupancy saturates at both ends:
//    - Exit done at 0: stays 0 and count_err pulses.
//    - Entry done at CAPACITY: cannot occur (entry not granted when full); guarded anyway by saturation.
//  - lot_full is updated in the same cycle as occupancy.
//    A full lot still grants exit; freed capacity re-enables entry from the next IDLE decision.
//  - pass_done/pass_abort in IDLE or HOLDOFF are ignored, with no counter or flag effect.
//  - rst in any state forces IDLE, clears the timer and occupancy, and sets last_served = EXIT.
//    Outputs take reset values on the next edge.
// CONFIGURATION
//  PRIORITY_EXIT_EN defined: on contention in IDLE, exit always wins (round-robin disabled).
//    last_served is still tracked but unused.
//  PRIORITY_EXIT_EN undefined: round-robin arbitration as above.
// STRUCTURE
//  Shared header parking_defs.vh holds:
//    FSM state localparams (2-bit: IDLE=0, GNT_ENTRY=1, GNT_EXIT=2, HOLDOFF=3);
//    lane encoding LANE_ENTRY=0 / LANE_EXIT=1;
//    default CAPACITY/TIMEOUT constants.
//  Sub-module gate_timeout_timer (inputs clr/en; output expired; parameterised by TIMEOUT_CYCLES/TMR_W).
//  FSM, arbitration and occupancy counter stay in the top.
// TESTING
//  1. rst 2 cycles, entry_req=1 -> grant_entry=1 one cycle after IDLE.
//     pass_done -> HOLDOFF 1 cycle, occupancy 0->1.
//  2. entry_req=exit_req=1 held, occupancy=3, done on each grant -> grants alternate entry,exit,entry.
//     With PRIORITY_EXIT_EN: exit every time.
//  3. Fill to 8 (CAPACITY=8) -> lot_full=1; entry_req held gets no grant.
//     exit_req + pass_done -> occupancy 7, lot_full=0, then entry granted.
//  4. Grant entry, no done/abort for 64 cycles -> timeout pulses once, grant drops, occupancy unchanged.
//  5. Exit grant at occupancy 0 + pass_done -> occupancy stays 0, count_err pulses 1 cycle.
//     pass_done+pass_abort together -> treated as done.
//  6. rst asserted mid GNT_EXIT at occupancy 5 -> next cycle grants 0, occupancy 0, then entry wins first contention.

Source files
------------

// File: rtl/parking_lane_arbiter_pkg.sv
// Shared definitions for the parking lane arbiter: FSM states, lane encoding, default sizing.
package parking_lane_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GNT_ENTRY = 2'd1,
      GNT_EXIT  = 2'd2,
      HOLDOFF   = 2'd3
   } state_e;

   typedef enum logic {
      LANE_ENTRY = 1'b0,
      LANE_EXIT  = 1'b1
   } lane_e;

   localparam int unsigned DEF_CAPACITY       = 8;
   localparam int unsigned DEF_CNT_W          = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
   localparam int unsigned DEF_TMR_W          = 7;

endpackage

// File: rtl/parking_lane_arbiter_timer.sv
// Grant watchdog: counts cycles while a grant is open, flags the last allowed cycle.
module gate_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TMR_W          = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count 0 is the first grant cycle, so TIMEOUT_CYCLES-1 marks the final one.
   assign expired = en && !clr && (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/parking_lane_arbiter.sv
// Arbitrates the gate between entry and exit lanes and tracks lot occupancy.
// Build option: define PRIORITY_EXIT_EN to make exit always win contention.
module parking_lane_arbiter
   import parking_lane_arbiter_pkg::*;
#(
   parameter int unsigned CAPACITY       = DEF_CAPACITY,
   parameter int unsigned CNT_W          = DEF_CNT_W,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned TMR_W          = DEF_TMR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass_done,
   input  logic             pass_abort,
   output logic             grant_entry,
   output logic             grant_exit,
   output logic [CNT_W-1:0] occupancy,
   output logic             lot_full,
   output logic             timeout,
   output logic             count_err
);

   state_e           state_q, state_d;
   lane_e            last_served_q, last_served_d;
   lane_e            cur_lane;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             lot_full_q, lot_full_d;
   logic             grant_entry_q, grant_entry_d;
   logic             grant_exit_q, grant_exit_d;
   logic             timeout_q, timeout_d;
   logic             count_err_q, count_err_d;
   logic             entry_elig, exit_elig;
   logic             in_grant;
   logic             tmr_expired;

   assign in_grant = (state_q == GNT_ENTRY) || (state_q == GNT_EXIT);

   gate_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMR_W          (TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!in_grant),
      .en      (in_grant),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      occ_d         = occ_q;
      timeout_d     = 1'b0;
      count_err_d   = 1'b0;
      entry_elig    = entry_req && !lot_full_q;
      exit_elig     = exit_req;
      cur_lane      = (state_q == GNT_EXIT) ? LANE_EXIT : LANE_ENTRY;

      case (state_q)
         IDLE: begin
            if (entry_elig && exit_elig) begin
`ifdef PRIORITY_EXIT_EN
               state_d = GNT_EXIT;
`else
               state_d = (last_served_q == LANE_EXIT) ? GNT_ENTRY : GNT_EXIT;
`endif
            end else if (entry_elig) begin
               state_d = GNT_ENTRY;
            end else if (exit_elig) begin
               state_d = GNT_EXIT;
            end
         end
         GNT_ENTRY, GNT_EXIT: begin
            // done outranks abort, and either outranks the watchdog
            if (pass_done) begin
               state_d       = HOLDOFF;
               last_served_d = cur_lane;
               if (cur_lane == LANE_ENTRY) begin
                  if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + CNT_W'(1);
               end else if (occ_q != '0) begin
                  occ_d = occ_q - CNT_W'(1);
               end else begin
                  count_err_d = 1'b1;
               end
            end else if (pass_abort) begin
               state_d       = HOLDOFF;
               last_served_d = cur_lane;
            end else if (tmr_expired) begin
               state_d       = HOLDOFF;
               last_served_d = cur_lane;
               timeout_d     = 1'b1;
            end
         end
         HOLDOFF: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      lot_full_d    = (occ_d == CNT_W'(CAPACITY));
      grant_entry_d = (state_d == GNT_ENTRY);
      grant_exit_d  = (state_d == GNT_EXIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_served_q <= LANE_EXIT;
         occ_q         <= '0;
         lot_full_q    <= 1'b0;
         grant_entry_q <= 1'b0;
         grant_exit_q  <= 1'b0;
         timeout_q     <= 1'b0;
         count_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         occ_q         <= occ_d;
         lot_full_q    <= lot_full_d;
         grant_entry_q <= grant_entry_d;
         grant_exit_q  <= grant_exit_d;
         timeout_q     <= timeout_d;
         count_err_q   <= count_err_d;
      end
   end

   assign grant_entry = grant_entry_q;
   assign grant_exit  = grant_exit_q;
   assign occupancy   = occ_q;
   assign lot_full    = lot_full_q;
   assign timeout     = timeout_q;
   assign count_err   = count_err_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter: per-cycle vector table plus corner sequences.
module tb_parking_lane_arbiter;

`ifdef PRIORITY_EXIT_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       entry_req, exit_req, pass_done, pass_abort;
   logic       grant_entry, grant_exit, lot_full, timeout, count_err;
   logic [3:0] occupancy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst, en, ex, done, abrt;
      logic       ge, gx;
      logic [3:0] occ;
      logic       full, to, ce;
   } vec_t;

   vec_t vecs[$];

   parking_lane_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .pass_done   (pass_done),
      .pass_abort  (pass_abort),
      .grant_entry (grant_entry),
      .grant_exit  (grant_exit),
      .occupancy   (occupancy),
      .lot_full    (lot_full),
      .timeout     (timeout),
      .count_err   (count_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic en, input logic ex,
                        input logic d, input logic a);
      rst = r; entry_req = en; exit_req = ex; pass_done = d; pass_abort = a;
   endtask

   function automatic vec_t mk(input logic r, input logic en, input logic ex,
                               input logic d, input logic a, input logic ge,
                               input logic gx, input int occ, input logic full,
                               input logic to, input logic ce);
      vec_t v;
      v.rst = r; v.en = en; v.ex = ex; v.done = d; v.abrt = a;
      v.ge = ge; v.gx = gx; v.occ = 4'(occ); v.full = full; v.to = to; v.ce = ce;
      return v;
   endfunction

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Inputs applied before an edge; expected outputs just after it.
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,0, 0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,1,0, 0,0,1,0,0,0));   // done in IDLE ignored
      vecs.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0));
      vecs.push_back(mk(0,0,1,1,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,0,1,0,0, 0,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,1, 0,0,0,0,0,1));   // exit at 0, done+abort
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0));   // abort: no count change
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(mk(0,1,0,0,0, 1,0,k,0,0,0));
         vecs.push_back(mk(0,1,0,1,0, 0,0,k+1,0,0,0));
         vecs.push_back(mk(0,1,0,0,0, 0,0,k+1,0,0,0));
      end
      // Contention at occupancy 3, last served = entry.
      vecs.push_back(mk(0,1,1,0,0, 0,1,3,0,0,0));
      vecs.push_back(mk(0,1,1,1,0, 0,0,2,0,0,0));
      vecs.push_back(mk(0,1,1,0,0, 0,0,2,0,0,0));
      vecs.push_back(mk(0,1,1,0,0, !PRIO,PRIO,2,0,0,0));
      vecs.push_back(mk(0,1,1,1,0, 0,0,PRIO ? 1 : 3,0,0,0));
      vecs.push_back(mk(0,1,1,0,0, 0,0,PRIO ? 1 : 3,0,0,0));
      vecs.push_back(mk(0,1,1,0,0, 0,1,PRIO ? 1 : 3,0,0,0));
      vecs.push_back(mk(0,0,0,1,0, 0,0,PRIO ? 0 : 2,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,PRIO ? 0 : 2,0,0,0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].ex, vecs[i].done, vecs[i].abrt);
         step();
         chk($sformatf("vec%0d.grant_entry", i), int'(grant_entry), int'(vecs[i].ge));
         chk($sformatf("vec%0d.grant_exit", i),  int'(grant_exit),  int'(vecs[i].gx));
         chk($sformatf("vec%0d.occupancy", i),   int'(occupancy),   int'(vecs[i].occ));
         chk($sformatf("vec%0d.lot_full", i),    int'(lot_full),    int'(vecs[i].full));
         chk($sformatf("vec%0d.timeout", i),     int'(timeout),     int'(vecs[i].to));
         chk($sformatf("vec%0d.count_err", i),   int'(count_err),   int'(vecs[i].ce));
      end

      // Fill the lot to capacity.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         entry_req = 1'b1;
         step();
         chk("fill.grant_entry", int'(grant_entry), 1);
         entry_req = 1'b0; pass_done = 1'b1;
         step();
         pass_done = 1'b0;
         chk("fill.occupancy", int'(occupancy), k + 1);
         step();
      end
      chk("full.lot_full", int'(lot_full), 1);
      entry_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("full.no_entry_grant", int'(grant_entry), 0);
      end
      exit_req = 1'b1;
      step();
      chk("full.grant_exit", int'(grant_exit), 1);
      chk("full.grant_entry_off", int'(grant_entry), 0);
      exit_req = 1'b0; pass_done = 1'b1;
      step();
      pass_done = 1'b0;
      chk("free.occupancy", int'(occupancy), 7);
      chk("free.lot_full", int'(lot_full), 0);
      step();
      step();
      chk("free.grant_entry", int'(grant_entry), 1);

      // Stalled entry grant released by the watchdog after 64 cycles.
      entry_req = 1'b0;
      for (int k = 1; k < 64; k++) begin
         step();
         chk($sformatf("tmo.hold%0d", k), int'(grant_entry && !timeout), 1);
      end
      step();
      chk("tmo.timeout", int'(timeout), 1);
      chk("tmo.grant_drop", int'(grant_entry), 0);
      chk("tmo.occupancy", int'(occupancy), 7);
      step();
      chk("tmo.single_pulse", int'(timeout), 0);

      // Bring occupancy to 5, then reset in the middle of an exit grant.
      for (int k = 0; k < 2; k++) begin
         step();
         exit_req = 1'b1;
         step();
         chk("drain.grant_exit", int'(grant_exit), 1);
         exit_req = 1'b0; pass_done = 1'b1;
         step();
         pass_done = 1'b0;
         chk("drain.occupancy", int'(occupancy), 6 - k);
      end
      step();
      exit_req = 1'b1;
      step();
      chk("rst.grant_exit_before", int'(grant_exit), 1);
      chk("rst.occ_before", int'(occupancy), 5);
      rst = 1'b1;
      step();
      chk("rst.grant_exit", int'(grant_exit), 0);
      chk("rst.grant_entry", int'(grant_entry), 0);
      chk("rst.occupancy", int'(occupancy), 0);
      rst = 1'b0; entry_req = 1'b1; exit_req = 1'b1;
      step();
      chk("rst.first_contention_entry", int'(grant_entry), PRIO ? 0 : 1);
      chk("rst.first_contention_exit", int'(grant_exit), PRIO ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
